// File: rtl/moore_sequence_generator_11_01_10_if.sv
// Request/stream bundle between a stimulus driver and the
// 11-01-10 sequence generator.
interface moore_sequence_generator_11_01_10_if;
    logic       start;
    logic [3:0] count;
    logic [1:0] X;
    logic       busy;
    logic       done;

    modport master (
        output start,
        output count,
        input  X,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  count,
        output X,
        output busy,
        output done
    );
endinterface

// File: rtl/moore_sequence_generator_11_01_10.sv
// Moore generator emitting N triplets of 11,01,10 with an
// optional idle gap between triplets; outputs are registered.
module moore_sequence_generator_11_01_10 #(
    parameter int GAP = 1
) (
    input  logic Ck,
    input  logic reset_,
    moore_sequence_generator_11_01_10_if.slave bus
);
    localparam logic [3:0] GAP_V = 4'(GAP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_P11,
        S_P01,
        S_P10,
        S_GAP,
        S_DONE
    } state_t;

    state_t     r_state;
    logic [3:0] r_rep_left;
    logic [3:0] r_gap_cnt;
    logic [1:0] r_x;
    logic       r_busy;
    logic       r_done;

    // Outputs are loaded with the value that belongs to the
    // state being entered, so they stay pure functions of state.
    always_ff @(posedge Ck or negedge reset_) begin
        if (!reset_) begin
            r_state    <= S_IDLE;
            r_rep_left <= 4'd0;
            r_gap_cnt  <= 4'd0;
            r_x        <= 2'b00;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_x    <= 2'b00;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.count != 4'd0) begin
                            r_rep_left <= bus.count;
                            r_state    <= S_P11;
                            r_x        <= 2'b11;
                            r_busy     <= 1'b1;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_P11: begin
                    r_state <= S_P01;
                    r_x     <= 2'b01;
                    r_busy  <= 1'b1;
                end
                S_P01: begin
                    r_state <= S_P10;
                    r_x     <= 2'b10;
                    r_busy  <= 1'b1;
                end
                S_P10: begin
                    if (r_rep_left == 4'd1) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_rep_left <= r_rep_left - 4'd1;
                        r_busy     <= 1'b1;
                        if (GAP_V == 4'd0) begin
                            r_state <= S_P11;
                            r_x     <= 2'b11;
                        end else begin
                            r_gap_cnt <= GAP_V;
                            r_state   <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    r_busy <= 1'b1;
                    if (r_gap_cnt == 4'd1) begin
                        r_state <= S_P11;
                        r_x     <= 2'b11;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.X    = r_x;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
endmodule

// File: tb/tb_moore_sequence_generator_11_01_10.sv
// Bench for the 11-01-10 generator: three instances with
// GAP=0,1,2 checked against a symbol-list reference model.
module tb_moore_sequence_generator_11_01_10;
    logic       Ck;
    logic       reset_;
    logic       start_d [3];
    logic [3:0] count_d [3];
    logic [1:0] x_o     [3];
    logic       busy_o  [3];
    logic       done_o  [3];

    int checks = 0;
    int errors = 0;

    logic [1:0] exp_x [$];
    logic [3:0] obs [0:255];

    moore_sequence_generator_11_01_10_if bus0 ();
    moore_sequence_generator_11_01_10_if bus1 ();
    moore_sequence_generator_11_01_10_if bus2 ();

    moore_sequence_generator_11_01_10 #(.GAP(0)) u0 (
        .Ck(Ck), .reset_(reset_), .bus(bus0)
    );
    moore_sequence_generator_11_01_10 #(.GAP(1)) u1 (
        .Ck(Ck), .reset_(reset_), .bus(bus1)
    );
    moore_sequence_generator_11_01_10 #(.GAP(2)) u2 (
        .Ck(Ck), .reset_(reset_), .bus(bus2)
    );

    assign bus0.start = start_d[0];
    assign bus1.start = start_d[1];
    assign bus2.start = start_d[2];
    assign bus0.count = count_d[0];
    assign bus1.count = count_d[1];
    assign bus2.count = count_d[2];
    assign x_o[0]    = bus0.X;
    assign x_o[1]    = bus1.X;
    assign x_o[2]    = bus2.X;
    assign busy_o[0] = bus0.busy;
    assign busy_o[1] = bus1.busy;
    assign busy_o[2] = bus2.busy;
    assign done_o[0] = bus0.done;
    assign done_o[1] = bus1.done;
    assign done_o[2] = bus2.done;

    initial Ck = 1'b0;
    always #5 Ck = ~Ck;

    // Reference: the symbol list a run of c triplets with gap g
    // puts on X, one entry per busy cycle.
    task automatic build_model(input int c, input int g);
        exp_x.delete();
        for (int r = 1; r <= c; r++) begin
            exp_x.push_back(2'b11);
            exp_x.push_back(2'b01);
            exp_x.push_back(2'b10);
            if (r < c)
                for (int z = 0; z < g; z++)
                    exp_x.push_back(2'b00);
        end
    endtask

    // Expected {X,busy,done} for the i-th cycle after the start edge.
    function automatic logic [3:0] exp_word(input int i);
        if (i < exp_x.size())
            return {exp_x[i], 1'b1, 1'b0};
        else if (i == exp_x.size())
            return 4'b0001;
        else
            return 4'b0000;
    endfunction

    function automatic logic [3:0] cur_word(input int sel);
        return {x_o[sel], busy_o[sel], done_o[sel]};
    endfunction

    // Records n cycles starting with the one after the next edge.
    task automatic capture(input int sel, input int n, input bit hold);
        for (int j = 0; j < n; j++) begin
            @(posedge Ck);
            #1;
            if (!hold && j == 0) begin
                start_d[sel] = 1'b0;
                count_d[sel] = 4'($urandom);
            end
            obs[j] = cur_word(sel);
        end
        start_d[sel] = 1'b0;
    endtask

    task automatic test_reset();
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (cur_word(s) !== 4'b0000) begin
                errors++;
                $display("FAIL reset_state dut%0d got %b want 0000",
                         s, cur_word(s));
            end
        end
        @(negedge Ck);
        reset_ = 1'b1;
        start_d[1] = 1'b1;
        count_d[1] = 4'd2;
        @(posedge Ck);
        #1;
        start_d[1] = 1'b0;
        @(posedge Ck);
        #1;
        checks++;
        if (cur_word(1) !== 4'b0110) begin
            errors++;
            $display("FAIL reset_pre_p01 got %b want 0110", cur_word(1));
        end
        #2;
        reset_ = 1'b0;
        #1;
        checks++;
        if (cur_word(1) !== 4'b0000) begin
            errors++;
            $display("FAIL reset_async got %b want 0000", cur_word(1));
        end
        @(negedge Ck);
        reset_ = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(posedge Ck);
            #1;
            checks++;
            if (cur_word(1) !== 4'b0000) begin
                errors++;
                $display("FAIL reset_idle c%0d got %b want 0000",
                         j, cur_word(1));
            end
        end
    endtask

    task automatic test_single();
        build_model(1, 1);
        start_d[1] = 1'b1;
        count_d[1] = 4'd1;
        capture(1, 6, 1'b0);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (obs[i] !== exp_word(i)) begin
                errors++;
                $display("FAIL single c%0d got %b want %b",
                         i, obs[i], exp_word(i));
            end
        end
    endtask

    task automatic test_gap();
        build_model(3, 2);
        start_d[2] = 1'b1;
        count_d[2] = 4'd3;
        capture(2, 16, 1'b0);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (obs[i] !== exp_word(i)) begin
                errors++;
                $display("FAIL gap c%0d got %b want %b",
                         i, obs[i], exp_word(i));
            end
        end
    endtask

    task automatic test_back_to_back();
        build_model(15, 0);
        start_d[0] = 1'b1;
        count_d[0] = 4'd15;
        capture(0, 48, 1'b0);
        for (int i = 0; i < 48; i++) begin
            checks++;
            if (obs[i] !== exp_word(i)) begin
                errors++;
                $display("FAIL b2b c%0d got %b want %b",
                         i, obs[i], exp_word(i));
            end
        end
    endtask

    // Held start: each run is len busy + DONE + one IDLE cycle.
    task automatic test_held_start();
        int per;
        build_model(2, 1);
        per = exp_x.size() + 2;
        start_d[1] = 1'b1;
        count_d[1] = 4'd2;
        capture(1, 2 * per, 1'b1);
        for (int i = 0; i < 2 * per; i++) begin
            checks++;
            if (obs[i] !== exp_word(i % per)) begin
                errors++;
                $display("FAIL held c%0d got %b want %b",
                         i, obs[i], exp_word(i % per));
            end
        end
    endtask

    task automatic test_zero();
        int s;
        s = $urandom_range(0, 2);
        build_model(0, s);
        start_d[s] = 1'b1;
        count_d[s] = 4'd0;
        capture(s, 3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs[i] !== exp_word(i)) begin
                errors++;
                $display("FAIL zero dut%0d c%0d got %b want %b",
                         s, i, obs[i], exp_word(i));
            end
        end
    endtask

    task automatic test_reset_mid();
        build_model(4, 2);
        start_d[2] = 1'b1;
        count_d[2] = 4'd4;
        for (int i = 0; i < 9; i++) begin
            @(posedge Ck);
            #1;
            start_d[2] = 1'b0;
            checks++;
            if (cur_word(2) !== exp_word(i)) begin
                errors++;
                $display("FAIL mid_pre c%0d got %b want %b",
                         i, cur_word(2), exp_word(i));
            end
        end
        #2;
        reset_ = 1'b0;
        #1;
        checks++;
        if (cur_word(2) !== 4'b0000) begin
            errors++;
            $display("FAIL mid_async got %b want 0000", cur_word(2));
        end
        @(posedge Ck);
        @(negedge Ck);
        reset_ = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(posedge Ck);
            #1;
            checks++;
            if (cur_word(2) !== 4'b0000) begin
                errors++;
                $display("FAIL mid_idle c%0d got %b want 0000",
                         j, cur_word(2));
            end
        end
        build_model(1, 2);
        start_d[2] = 1'b1;
        count_d[2] = 4'd1;
        capture(2, 5, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs[i] !== exp_word(i)) begin
                errors++;
                $display("FAIL mid_fresh c%0d got %b want %b",
                         i, obs[i], exp_word(i));
            end
        end
    endtask

    task automatic test_random();
        int s;
        int c;
        int n;
        for (int it = 0; it < 20; it++) begin
            s = $urandom_range(0, 2);
            c = $urandom_range(0, 15);
            repeat ($urandom_range(0, 2)) @(posedge Ck);
            #1;
            build_model(c, s);
            n = exp_x.size() + 3;
            start_d[s] = 1'b1;
            count_d[s] = 4'(c);
            capture(s, n, 1'b0);
            for (int i = 0; i < n; i++) begin
                checks++;
                if (obs[i] !== exp_word(i)) begin
                    errors++;
                    $display("FAIL rand it%0d dut%0d n%0d c%0d got %b want %b",
                             it, s, c, i, obs[i], exp_word(i));
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset_ = 1'b0;
        for (int s = 0; s < 3; s++) begin
            start_d[s] = 1'b0;
            count_d[s] = 4'd0;
        end
        #12;
        test_reset();
        test_single();
        test_gap();
        test_back_to_back();
        test_held_start();
        test_zero();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
